// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM status codes, arbiter states and the word type.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2,
    FAULT  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/wait_counter.sv
// Counts cycles a granted request has spent waiting on the RAM; flags once TIMEOUT is reached.
module wait_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign expired_o = (count_q >= CNT_W'(TIMEOUT));

  // Saturate at TIMEOUT so the flag can never wrap back to zero.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !expired_o) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data requests win over fetches, no preemption, one bubble
// between accesses, and a sticky fault on RAM error or wait timeout.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  input  logic              halt,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              mem_fault
);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] iaddr_q, iaddr_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [DATA_W-1:0] dstore_q, dstore_d;
  logic              dren_q, dren_d;
  logic              dwen_q, dwen_d;

  ramstate_t rstate;
  logic      d_req;
  logic      in_grant;
  logic      cnt_clr;
  logic      cnt_en;
  logic      cnt_expired;

  assign rstate    = ramstate_t'(ramstate);
  assign d_req     = dREN | dWEN;
  assign in_grant  = (state_q == DGRANT) || (state_q == IGRANT);
  assign cnt_clr   = !in_grant;
  assign cnt_en    = in_grant && ((rstate == FREE) || (rstate == BUSY));
  assign mem_fault = (state_q == FAULT);

  wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_counter (
    .clk       (CLK),
    .rst_n     (nRST),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .expired_o (cnt_expired)
  );

  always_comb begin
    state_d  = state_q;
    iaddr_d  = iaddr_q;
    daddr_d  = daddr_q;
    dstore_d = dstore_q;
    dren_d   = dren_q;
    dwen_d   = dwen_q;
    ihit     = 1'b0;
    dhit     = 1'b0;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    case (state_q)
      IDLE: begin
        if (d_req) begin
          state_d  = DGRANT;
          daddr_d  = daddr;
          dstore_d = dstore;
          dren_d   = dREN;
          dwen_d   = dWEN;
        end else if (iREN && !halt) begin
          state_d = IGRANT;
          iaddr_d = iaddr;
        end
      end

      // Enables follow the live request so a withdrawal drops them in the same cycle.
      DGRANT: begin
        ramaddr  = daddr_q;
        ramstore = dstore_q;
        if (d_req) begin
          ramWEN = dwen_q;
          ramREN = dren_q & ~dwen_q;
        end
        if (rstate == ERROR) begin
          state_d = FAULT;
        end else if (!d_req) begin
          state_d = IDLE;
        end else if (rstate == ACCESS) begin
          dhit    = 1'b1;
          dload   = ramload;
          state_d = IDLE;
        end else if (cnt_expired) begin
          state_d = FAULT;
        end
      end

      IGRANT: begin
        ramaddr = iaddr_q;
        ramREN  = iREN;
        if (rstate == ERROR) begin
          state_d = FAULT;
        end else if (!iREN) begin
          state_d = IDLE;
        end else if (rstate == ACCESS) begin
          ihit    = 1'b1;
          iload   = ramload;
          state_d = IDLE;
        end else if (cnt_expired) begin
          state_d = FAULT;
        end
      end

      FAULT: begin
        state_d = FAULT;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      iaddr_q  <= '0;
      daddr_q  <= '0;
      dstore_q <= '0;
      dren_q   <= 1'b0;
      dwen_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      iaddr_q  <= iaddr_d;
      daddr_q  <= daddr_d;
      dstore_q <= dstore_d;
      dren_q   <= dren_d;
      dwen_q   <= dwen_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random transactions against a
// word-level memory model; the bench also plays the part of the RAM.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, halt = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]  ramstate = 2'd0;
  logic        ihit, dhit, ramREN, ramWEN, mem_fault;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int    assertions = 0;
  int    failures   = 0;
  word_t ram_mem [256];
  word_t ref_mem [256];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .halt(halt), .ihit(ihit), .iload(iload),
    .dhit(dhit), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate), .mem_fault(mem_fault)
  );

  always #5 CLK = ~CLK;

  // RAM storage: a write lands when the RAM reports ACCESS.
  always @(negedge CLK) begin
    if (ramWEN && ramstate == ACCESS) ram_mem[ramaddr[9:2]] <= ramstore;
  end

  always @(negedge CLK) begin
    if (nRST) begin
      assertions++;
      assert (!(ihit && dhit)) else begin
        failures++;
        $error("FAIL hit_overlap: observed ihit=%b dhit=%b expected not both", ihit, dhit);
      end
      assertions++;
      assert (!(ramREN && ramWEN)) else begin
        failures++;
        $error("FAIL en_overlap: observed ren=%b wen=%b expected not both", ramREN, ramWEN);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertions++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic chk_quiet(input string tag, input logic fault_exp, input logic full);
    chk({tag, "_ctl"}, {27'd0, ihit, dhit, ramREN, ramWEN, mem_fault}, {31'd0, fault_exp});
    chk({tag, "_load"}, iload | dload, 32'd0);
    if (full) chk({tag, "_bus"}, ramaddr | ramstore, 32'd0);
  endtask

  task automatic async_reset(input string tag);
    #2;
    nRST = 1'b0;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0; ramstate = FREE;
    #1 chk_quiet(tag, 1'b0, 1'b1);
    @(negedge CLK);
    nRST = 1'b1;
    smp();
    chk_quiet({tag, "_idle"}, 1'b0, 1'b0);
  endtask

  // kind: 0 fetch, 1 data read, 2 data write, 3 read+write (write wins).
  // busy: BUSY cycles before ACCESS; the hit lands in grant cycle busy+1.
  task automatic run_txn(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                         input int busy);
    int idx;
    idx = int'(addr[9:2]);
    cyc();
    iREN = (kind == 0); dREN = (kind == 1 || kind == 3); dWEN = (kind >= 2);
    iaddr = (kind == 0) ? addr : $urandom;
    daddr = (kind == 0) ? $urandom : addr;
    dstore = wdata; ramstate = FREE; ramload = $urandom;
    smp();
    chk_quiet("txn_idle", 1'b0, 1'b0);
    for (int g = 0; g <= busy; g++) begin
      cyc();
      if (kind == 0) iaddr = $urandom;
      else begin daddr = $urandom; dstore = $urandom; end
      ramstate = (g < busy) ? BUSY : ACCESS;
      ramload  = (g < busy) ? $urandom : ram_mem[ramaddr[9:2]];
      smp();
      chk("txn_ren", ramREN, kind <= 1);
      chk("txn_wen", ramWEN, kind >= 2);
      chk("txn_addr", ramaddr, addr);
      if (kind >= 2) chk("txn_store", ramstore, wdata);
      chk("txn_ihit", ihit, (g == busy) && (kind == 0));
      chk("txn_dhit", dhit, (g == busy) && (kind != 0));
      if (g == busy) begin
        if (kind == 0) chk("txn_iload", iload, ref_mem[idx]);
        else if (kind == 1) chk("txn_dload", dload, ref_mem[idx]);
        else ref_mem[idx] = wdata;
      end
    end
    cyc();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE; ramload = $urandom;
    smp();
    chk_quiet("txn_bubble", 1'b0, 1'b0);
    $display("txn kind=%0d addr=%h wdata=%h busy=%0d", kind, addr, wdata, busy);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    ram_mem[16] = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;

    repeat (2) @(negedge CLK);
    chk_quiet("reset", 1'b0, 1'b1);
    nRST = 1'b1;

    run_txn(0, 32'h40, 32'h0, 2);

    // Fetch and write raised together: data first, fetch after the bubble.
    cyc(); iREN = 1; iaddr = 32'h40; dWEN = 1; daddr = 32'h80; dstore = 32'h1234;
    smp(); chk_quiet("both_idle", 1'b0, 1'b0);
    cyc(); ramstate = ACCESS; ramload = $urandom;
    smp(); chk("both_wen", ramWEN, 1); chk("both_ren", ramREN, 0);
    chk("both_addr", ramaddr, 32'h80); chk("both_store", ramstore, 32'h1234);
    chk("both_dhit", dhit, 1); chk("both_ihit0", ihit, 0);
    ref_mem[32] = 32'h1234;
    cyc(); dWEN = 0; ramstate = FREE;
    smp(); chk_quiet("both_bubble", 1'b0, 1'b0);
    cyc(); ramstate = ACCESS; ramload = ram_mem[ramaddr[9:2]];
    smp(); chk("both_ihit", ihit, 1); chk("both_iaddr", ramaddr, 32'h40);
    chk("both_iload", iload, ref_mem[16]);
    cyc(); iREN = 0; ramstate = FREE;
    smp(); chk_quiet("both_end", 1'b0, 1'b0);
    run_txn(1, 32'h80, 32'h0, 0);

    // Data request during a fetch waits; halt mid-fetch does not abort it.
    cyc(); iREN = 1; iaddr = 32'h44;
    smp(); chk_quiet("pre_idle", 1'b0, 1'b0);
    cyc(); ramstate = BUSY; dREN = 1; daddr = 32'h88; halt = 1;
    smp(); chk("pre_ren", ramREN, 1); chk("pre_wen", ramWEN, 0);
    chk("pre_addr", ramaddr, 32'h44); chk("pre_hits", {ihit, dhit}, 0);
    cyc(); ramstate = ACCESS; ramload = ram_mem[ramaddr[9:2]];
    smp(); chk("pre_ihit", ihit, 1); chk("pre_dhit0", dhit, 0);
    chk("pre_iload", iload, ref_mem[17]); chk("pre_iaddr", ramaddr, 32'h44);
    cyc(); iREN = 0; halt = 0; ramstate = FREE;
    smp(); chk_quiet("pre_bubble", 1'b0, 1'b0);
    cyc(); ramstate = ACCESS; ramload = ram_mem[ramaddr[9:2]];
    smp(); chk("pre_dhit", dhit, 1); chk("pre_dren", ramREN, 1);
    chk("pre_daddr", ramaddr, 32'h88); chk("pre_dload", dload, ref_mem[34]);
    cyc(); dREN = 0; ramstate = FREE;
    smp(); chk_quiet("pre_end", 1'b0, 1'b0);

    // halt blocks fetch grants but not data.
    cyc(); halt = 1; iREN = 1; iaddr = 32'h48;
    for (int i = 0; i < 10; i++) begin
      smp(); chk_quiet("halt_block", 1'b0, 1'b0);
      cyc();
    end
    dREN = 1; daddr = 32'h8C;
    smp(); chk_quiet("halt_didle", 1'b0, 1'b0);
    cyc(); ramstate = ACCESS; ramload = ram_mem[ramaddr[9:2]];
    smp(); chk("halt_dhit", dhit, 1); chk("halt_daddr", ramaddr, 32'h8C);
    chk("halt_dload", dload, ref_mem[35]);
    cyc(); dREN = 0; ramstate = FREE;
    smp(); chk_quiet("halt_bubble", 1'b0, 1'b0);
    cyc(); halt = 0;
    smp(); chk_quiet("halt_release", 1'b0, 1'b0);
    cyc(); ramstate = ACCESS; ramload = ram_mem[ramaddr[9:2]];
    smp(); chk("halt_ihit", ihit, 1); chk("halt_iload", iload, ref_mem[18]);
    cyc(); iREN = 0; ramstate = FREE;
    smp(); chk_quiet("halt_end", 1'b0, 1'b0);

    // Withdrawal after two BUSY cycles; a following full-length wait must not fault.
    cyc(); dREN = 1; daddr = 32'h90;
    smp(); chk_quiet("wd_idle", 1'b0, 1'b0);
    repeat (2) begin
      cyc(); ramstate = BUSY;
      smp(); chk("wd_ren", ramREN, 1);
    end
    cyc(); dREN = 0; ramstate = ACCESS; ramload = $urandom;
    smp(); chk_quiet("wd_drop", 1'b0, 1'b0);
    run_txn(0, 32'h4C, 32'h0, TO);

    for (int n = 0; n < 24; n++) begin
      run_txn(int'($urandom_range(0, 3)), {22'd0, 8'($urandom), 2'b00}, $urandom,
              int'($urandom_range(0, TO)));
    end

    // Timeout: TO waiting cycles are tolerated, the next one faults.
    cyc(); dREN = 1; daddr = 32'h94; ramstate = FREE;
    smp(); chk_quiet("to_idle", 1'b0, 1'b0);
    for (int k = 1; k <= TO + 1; k++) begin
      cyc(); ramstate = BUSY;
      smp(); chk("to_wait_ren", ramREN, 1); chk("to_wait_fault", mem_fault, 0);
    end
    cyc();
    smp(); chk_quiet("to_fault", 1'b1, 1'b0);
    repeat (3) begin
      cyc(); ramstate = ACCESS; iREN = 1;
      smp(); chk_quiet("to_sticky", 1'b1, 1'b0);
    end
    async_reset("to_rst");

    // RAM error faults the cycle after, with no hit.
    cyc(); dWEN = 1; daddr = 32'h98; dstore = 32'h5555;
    smp(); chk_quiet("err_idle", 1'b0, 1'b0);
    cyc(); ramstate = ERROR;
    smp(); chk("err_dhit", dhit, 0); chk("err_nofault", mem_fault, 0);
    cyc(); ramstate = FREE;
    smp(); chk_quiet("err_fault", 1'b1, 1'b0);
    async_reset("err_rst");

    // Asynchronous reset while a write is in flight.
    cyc(); dWEN = 1; daddr = 32'h9C; dstore = 32'hA5A5;
    smp(); chk_quiet("rw_idle", 1'b0, 1'b0);
    cyc(); ramstate = BUSY;
    smp(); chk("rw_wen", ramWEN, 1);
    async_reset("rw_rst");
    run_txn(1, 32'h9C, 32'h0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
